// File: rtl/chip8_vga_pkg.sv
// Shared constants and types for the Chip-8 VGA scan-out path.
// All horizontal values are in clk50 cycles (two per VGA pixel).
package chip8_vga_pkg;

  localparam int unsigned HCOUNT_W  = 11;
  localparam int unsigned VCOUNT_W  = 10;
  localparam int unsigned COLOR_W   = 8;
  localparam int unsigned CX_W      = 6;
  localparam int unsigned CY_W      = 5;
  localparam int unsigned FB_ADDR_W = CY_W + CX_W;

  localparam int unsigned H_VISIBLE = 1280;
  localparam int unsigned H_FRONT   = 32;
  localparam int unsigned H_SYNC    = 192;
  localparam int unsigned H_BACK    = 96;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int unsigned SCALE     = 10;
  localparam int unsigned V_OFFSET  = 80;
  localparam int unsigned CHIP8_W   = 64;
  localparam int unsigned CHIP8_H   = 32;
  localparam int unsigned V_WIN_END = V_OFFSET + SCALE * CHIP8_H;
  localparam int unsigned FB_DEPTH  = CHIP8_W * CHIP8_H;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  localparam rgb_t COLOR_LIT   = rgb_t'(24'hFF_FF_FF);
  localparam rgb_t COLOR_AMBER = rgb_t'(24'hFF_B0_00);
  localparam rgb_t COLOR_BLACK = rgb_t'(24'h00_00_00);

  // True when a scan position lands inside the scaled 64x32 image.
  function automatic logic in_chip8_window(input logic [HCOUNT_W-1:0] h,
                                           input logic [VCOUNT_W-1:0] v);
    return (h < HCOUNT_W'(H_VISIBLE)) &&
           (v >= VCOUNT_W'(V_OFFSET)) && (v < VCOUNT_W'(V_WIN_END));
  endfunction

  // Row-major framebuffer address: y*64 + x.
  function automatic fb_addr_t chip8_fb_addr(input logic [CY_W-1:0] cy,
                                             input logic [CX_W-1:0] cx);
    return fb_addr_t'({cy, cx});
  endfunction

endpackage

// File: rtl/chip8_fb_dpram.sv
// 2048x1 true dual-port framebuffer RAM, registered address, one-cycle read.
// Same-port read-during-write returns the old contents.
module chip8_fb_dpram
  import chip8_vga_pkg::*;
(
  input  logic     clock,
  input  fb_addr_t address_a,
  input  fb_addr_t address_b,
  input  logic     data_a,
  input  logic     data_b,
  input  logic     wren_a,
  input  logic     wren_b,
  output logic     q_a,
  output logic     q_b
);

  logic mem_q [FB_DEPTH];

  // Single process keeps both write ports on one driver; port b wins a collision.
  always_ff @(posedge clock) begin
    if (wren_a) mem_q[address_a] <= data_a;
    if (wren_b) mem_q[address_b] <= data_b;
    q_a <= mem_q[address_a];
    q_b <= mem_q[address_b];
  end

endmodule

// File: rtl/chip8_vga_emulator.sv
// 640x480@60 VGA scan-out of the 64x32 Chip-8 image, 10x scaled, from clk50.
// Optional amber tint of lit pixels while paused: define CHIP8_PAUSE_TINT_EN.
module chip8_vga_emulator
  import chip8_vga_pkg::*;
(
  input  logic                 clk50,
  input  logic                 reset,
  input  logic                 fb_pixel_data,
  output logic [FB_ADDR_W-1:0] fb_request_addr,
  input  logic                 is_paused,
  output logic [COLOR_W-1:0]   VGA_R,
  output logic [COLOR_W-1:0]   VGA_G,
  output logic [COLOR_W-1:0]   VGA_B,
  output logic                 VGA_CLK,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_BLANK_n,
  output logic                 VGA_SYNC_n
);

  logic [HCOUNT_W-1:0] hcount_q, hcount_d;
  logic [VCOUNT_W-1:0] vcount_q, vcount_d;
  logic [CX_W-1:0]     cx_look;
  logic [CY_W-1:0]     cy_look;
  logic                look_win;
  logic                pix_win;
  rgb_t                rgb;

  always_comb begin
    hcount_d = hcount_q + HCOUNT_W'(1);
    vcount_d = vcount_q;
    if (hcount_q == HCOUNT_W'(H_TOTAL - 1)) begin
      hcount_d = '0;
      vcount_d = (vcount_q == VCOUNT_W'(V_TOTAL - 1)) ? '0 : vcount_q + VCOUNT_W'(1);
    end
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  // Next counter value is the lookahead position, so RAM data lines up with the pixel.
  assign look_win = in_chip8_window(hcount_d, vcount_d);
  assign cx_look  = CX_W'(hcount_d[HCOUNT_W-1:1] / VCOUNT_W'(SCALE));
  assign cy_look  = CY_W'((vcount_d - VCOUNT_W'(V_OFFSET)) / VCOUNT_W'(SCALE));
  assign fb_request_addr = (reset && look_win) ? chip8_fb_addr(cy_look, cx_look) : '0;

  assign pix_win = in_chip8_window(hcount_q, vcount_q);

  always_comb begin
    rgb = COLOR_BLACK;
    if (reset && pix_win && fb_pixel_data) begin
`ifdef CHIP8_PAUSE_TINT_EN
      rgb = is_paused ? COLOR_AMBER : COLOR_LIT;
`else
      rgb = COLOR_LIT;
`endif
    end
  end

`ifndef CHIP8_PAUSE_TINT_EN
  logic unused_is_paused;
  assign unused_is_paused = is_paused;
`endif

  assign VGA_R       = rgb.r;
  assign VGA_G       = rgb.g;
  assign VGA_B       = rgb.b;
  assign VGA_CLK     = reset && hcount_q[0];
  assign VGA_HS      = !(reset && (hcount_q >= HCOUNT_W'(H_SYNC_START)) &&
                                  (hcount_q <  HCOUNT_W'(H_SYNC_END)));
  assign VGA_VS      = !(reset && (vcount_q >= VCOUNT_W'(V_SYNC_START)) &&
                                  (vcount_q <  VCOUNT_W'(V_SYNC_END)));
  assign VGA_BLANK_n = reset && (hcount_q < HCOUNT_W'(H_VISIBLE)) &&
                                (vcount_q < VCOUNT_W'(V_VISIBLE));
  assign VGA_SYNC_n  = 1'b0;

endmodule

// File: tb/tb_chip8_vga_emulator.sv
// Directed bench for chip8_vga_emulator; a chip8_fb_dpram instance serves as the framebuffer.
module tb_chip8_vga_emulator;

  logic        clk50 = 1'b0;
  logic        reset;
  logic        fb_pixel_data;
  logic [10:0] fb_request_addr;
  logic        is_paused;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [23:0] rgb_w;
  logic [10:0] ram_wa;
  logic        ram_wd, ram_we, unused_qa;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk50 = ~clk50;
  assign rgb_w = {vga_r, vga_g, vga_b};

  chip8_vga_emulator dut (
    .clk50(clk50), .reset(reset), .fb_pixel_data(fb_pixel_data),
    .fb_request_addr(fb_request_addr), .is_paused(is_paused),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b), .VGA_CLK(vga_clk),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_n(vga_blank_n), .VGA_SYNC_n(vga_sync_n)
  );

  chip8_fb_dpram fb (
    .clock(clk50), .address_a(ram_wa), .address_b(fb_request_addr),
    .data_a(ram_wd), .data_b(1'b0), .wren_a(ram_we), .wren_b(1'b0),
    .q_a(unused_qa), .q_b(fb_pixel_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  task automatic wait_h(input int h);
    bit hit = 1'b0;
    for (int i = 0; i < 1700 && !hit; i++) begin
      if (dut.hcount_q == 11'(h)) hit = 1'b1;
      else step();
    end
    check($sformatf("reach_h%0d", h), 32'(hit), 32'd1);
  endtask

  task automatic ram_write(input int a, input logic d);
    @(negedge clk50);
    ram_wa = 11'(a);
    ram_wd = d;
    ram_we = 1'b1;
    @(negedge clk50);
    ram_we = 1'b0;
  endtask

  initial begin
    int n, m, cnt_blank, cnt_lit, first_w, last_w, n_w, n_other, h;
    logic b1279, b1280;
    bit done;
    logic [23:0] exp_pause;

    reset = 1'b0; is_paused = 1'b0; ram_we = 1'b0; ram_wa = '0; ram_wd = 1'b0;
    for (int a = 0; a < 2048; a++) ram_write(a, 1'b0);
    ram_write(5, 1'b1);
    step();

    // Held in reset: everything forced.
    check("rst_rgb", 32'(rgb_w), 32'h0);
    check("rst_hs", 32'(vga_hs), 32'd1);
    check("rst_vs", 32'(vga_vs), 32'd1);
    check("rst_blank", 32'(vga_blank_n), 32'd0);
    check("rst_addr", 32'(fb_request_addr), 32'd0);
    check("rst_vgaclk", 32'(vga_clk), 32'd0);
    check("sync_n", 32'(vga_sync_n), 32'd0);

    @(negedge clk50);
    reset = 1'b1;

    // Horizontal sync timing from reset release.
    n = 0; done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      step(); n++;
      if (!vga_hs) done = 1'b1;
    end
    check("hs_first_fall", 32'(n), 32'd1312);
    n = 0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (vga_hs) done = 1'b1;
      else begin step(); n++; end
    end
    check("hs_low_width", 32'(n), 32'd192);
    m = 0; done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      step(); m++;
      if (!vga_hs) done = 1'b1;
    end
    check("hs_period", 32'(n + m), 32'd1600);
    check("vgaclk_even", 32'(vga_clk), 32'd0);
    step();
    check("vgaclk_odd", 32'(vga_clk), 32'd1);

    // A full line above the Chip-8 window.
    wait_h(0);
    check("vcount_line2", 32'(dut.vcount_q), 32'd2);
    cnt_blank = 0; cnt_lit = 0;
    for (int i = 0; i < 1600; i++) begin
      if (vga_blank_n) cnt_blank++;
      if (rgb_w != 24'h0) cnt_lit++;
      step();
    end
    check("blank_high_count", 32'(cnt_blank), 32'd1280);
    check("black_outside_win", 32'(cnt_lit), 32'd0);

    // First Chip-8 row: address map and the single lit pixel at addr 5.
    force dut.vcount_q = 10'd80;
    step();
    wait_h(0);
    for (int i = 0; i < 19; i++) begin
      check($sformatf("addr_v80_h%0d", i), 32'(fb_request_addr), 32'd0);
      step();
    end
    check("addr_v80_h19", 32'(fb_request_addr), 32'd1);
    first_w = -1; last_w = -1; n_w = 0; n_other = 0; b1279 = 1'b0; b1280 = 1'b1;
    for (h = 19; h < 1600; h++) begin
      if (rgb_w == 24'hFFFFFF) begin
        if (first_w < 0) first_w = h;
        last_w = h; n_w++;
      end else if (rgb_w != 24'h0) n_other++;
      if (h == 1279) b1279 = vga_blank_n;
      if (h == 1280) b1280 = vga_blank_n;
      step();
    end
    check("white_first_h", 32'(first_w), 32'd100);
    check("white_last_h", 32'(last_w), 32'd119);
    check("white_count", 32'(n_w), 32'd20);
    check("other_colour", 32'(n_other), 32'd0);
    check("blank_h1279", 32'(b1279), 32'd1);
    check("blank_h1280", 32'(b1280), 32'd0);

    force dut.vcount_q = 10'd89;
    wait_h(100);
    check("pix_v89_h100", 32'(rgb_w), 32'hFFFFFF);
    force dut.vcount_q = 10'd90;
    step();
    wait_h(100);
    check("pix_v90_h100", 32'(rgb_w), 32'h0);
    wait_h(0);
    check("addr_v90_h0", 32'(fb_request_addr), 32'd64);
    force dut.vcount_q = 10'd79;
    wait_h(100);
    check("addr_v79", 32'(fb_request_addr), 32'd0);
    check("pix_v79_h100", 32'(rgb_w), 32'h0);
    force dut.vcount_q = 10'd400;
    #1;
    check("addr_v400", 32'(fb_request_addr), 32'd0);
    force dut.vcount_q = 10'd399;
    wait_h(1278);
    check("addr_v399_h1278", 32'(fb_request_addr), 32'd2047);
    step();
    check("addr_v399_h1279", 32'(fb_request_addr), 32'd0);

    // Vertical blank and sync decode.
    wait_h(10);
    force dut.vcount_q = 10'd479; #1;
    check("blank_v479", 32'(vga_blank_n), 32'd1);
    force dut.vcount_q = 10'd480; #1;
    check("blank_v480", 32'(vga_blank_n), 32'd0);
    force dut.vcount_q = 10'd489; #1;
    check("vs_v489", 32'(vga_vs), 32'd1);
    force dut.vcount_q = 10'd490; #1;
    check("vs_v490", 32'(vga_vs), 32'd0);
    force dut.vcount_q = 10'd491; #1;
    check("vs_v491", 32'(vga_vs), 32'd0);
    force dut.vcount_q = 10'd492; #1;
    check("vs_v492", 32'(vga_vs), 32'd1);

    // Mid-frame reset forces outputs without waiting for a clock edge.
    force dut.vcount_q = 10'd200;
    wait_h(700);
    check("addr_v200_h700", 32'(fb_request_addr), 32'd803);
    check("blank_v200_h700", 32'(vga_blank_n), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_addr", 32'(fb_request_addr), 32'd0);
    check("midrst_blank", 32'(vga_blank_n), 32'd0);
    check("midrst_hs", 32'(vga_hs), 32'd1);
    check("midrst_rgb", 32'(rgb_w), 32'h0);
    check("midrst_hcount", 32'(dut.hcount_q), 32'd0);
    release dut.vcount_q;
    step(); step();
    check("midrst_vcount", 32'(dut.vcount_q), 32'd0);

    // Pause tint with only address 0 lit.
    ram_write(5, 1'b0);
    ram_write(0, 1'b1);
    @(negedge clk50);
    reset = 1'b1;
    is_paused = 1'b1;
    force dut.vcount_q = 10'd80;
    step();
    wait_h(0);
`ifdef CHIP8_PAUSE_TINT_EN
    exp_pause = 24'hFFB000;
`else
    exp_pause = 24'hFFFFFF;
`endif
    check("pause_lit", 32'(rgb_w), 32'(exp_pause));
    is_paused = 1'b0; #1;
    check("unpaused_lit", 32'(rgb_w), 32'hFFFFFF);
    is_paused = 1'b1;
    wait_h(20);
    check("pause_unlit", 32'(rgb_w), 32'h0);
    release dut.vcount_q;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
